// File: rtl/plab4_net_router_output_ctrl_tp_pkg.sv
// Shared definitions for the TP router output controller and the input
// controllers that consume its grants.
package plab4_net_router_output_ctrl_tp_pkg;

   localparam int c_num_inputs = 3;
   localparam int c_sel_nbits  = 2;

   localparam int WEST = 0;
   localparam int TERM = 1;
   localparam int EAST = 2;

   // One-hot request/grant vector to crossbar index; zero vector maps to 0.
   function automatic logic [c_sel_nbits-1:0] onehot_to_idx(input logic [c_num_inputs-1:0] oh);
      logic [c_sel_nbits-1:0] idx;
      idx = '0;
      if (oh[EAST])      idx = 2'(EAST);
      else if (oh[TERM]) idx = 2'(TERM);
      else if (oh[WEST]) idx = 2'(WEST);
      return idx;
   endfunction

   // Next priority pointer: the bit just above the last winner, wrapping 2 -> 0.
   function automatic logic [c_num_inputs-1:0] rotl1(input logic [c_num_inputs-1:0] oh);
      return {oh[c_num_inputs-2:0], oh[c_num_inputs-1]};
   endfunction

endpackage

// File: rtl/plab4_net_rr_arb_prio.sv
// Combinational 3-way priority arbiter: first request at or above the
// one-hot priority bit wins, searching upward with wrap 2 -> 0.
module plab4_net_rr_arb_prio
   import plab4_net_router_output_ctrl_tp_pkg::*;
(
   input  logic [c_num_inputs-1:0] prio,
   input  logic [c_num_inputs-1:0] reqs,
   output logic [c_num_inputs-1:0] grant
);

   always_comb begin
      grant = '0;
      unique case (prio)
         3'b010: begin
            if (reqs[TERM])      grant = 3'b010;
            else if (reqs[EAST]) grant = 3'b100;
            else if (reqs[WEST]) grant = 3'b001;
         end
         3'b100: begin
            if (reqs[EAST])      grant = 3'b100;
            else if (reqs[WEST]) grant = 3'b001;
            else if (reqs[TERM]) grant = 3'b010;
         end
         // A corrupted (non-one-hot) pointer falls back to west-first order.
         default: begin
            if (reqs[WEST])      grant = 3'b001;
            else if (reqs[TERM]) grant = 3'b010;
            else if (reqs[EAST]) grant = 3'b100;
         end
      endcase
   end

endmodule

// File: rtl/plab4_net_router_output_ctrl_tp.sv
// Per-output-port controller for the timing-partitioned router: round-robin
// arbitration with an independent priority pointer per security domain.
module plab4_net_router_output_ctrl_tp
   import plab4_net_router_output_ctrl_tp_pkg::*;
#(
   parameter int p_num_inputs = c_num_inputs
)(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    domain0,
   input  logic                    domain1,
   input  logic [p_num_inputs-1:0] reqs,
   output logic [p_num_inputs-1:0] grants,
   output logic                    out_val,
   input  logic                    out_rdy,
   output logic [c_sel_nbits-1:0]  xbar_sel
);

   // Handshake: a flit moves when out_val && out_rdy on a rising edge;
   // out_val never waits on out_rdy, and grants carry the transfer back
   // to the inputs only in cycles where the transfer actually happens.

   logic [p_num_inputs-1:0] prio_d0;
   logic [p_num_inputs-1:0] prio_d1;
   logic [p_num_inputs-1:0] prio_sel;
   logic [p_num_inputs-1:0] arb_win;
   logic                    dom_valid;
   logic                    active_dom;
   logic                    xfer;

   assign dom_valid  = domain0 ^ domain1;
   assign active_dom = domain1;
   assign prio_sel   = active_dom ? prio_d1 : prio_d0;

   plab4_net_rr_arb_prio arb (
      .prio  (prio_sel),
      .reqs  (reqs),
      .grant (arb_win)
   );

   always_comb begin
      out_val  = 1'b0;
      grants   = '0;
      xbar_sel = '0;
      if (!reset && dom_valid) begin
         out_val  = |arb_win;
         xbar_sel = onehot_to_idx(arb_win);
         grants   = out_rdy ? arb_win : '0;
      end
   end

   assign xfer = out_val && out_rdy;

   // Only the active domain's pointer moves, so the other domain's grant
   // order is never influenced by this slot's traffic.
   always_ff @(posedge clk) begin
      if (reset) begin
         prio_d0 <= 3'b001;
         prio_d1 <= 3'b001;
      end else if (xfer) begin
         if (active_dom) prio_d1 <= rotl1(arb_win);
         else            prio_d0 <= rotl1(arb_win);
      end
   end

endmodule

// File: tb/tb_plab4_net_router_output_ctrl_tp.sv
// Bench for the TP output controller: directed scenarios with literal
// expectations, then randomized traffic against a per-domain pointer model.
module tb_plab4_net_router_output_ctrl_tp;

   logic       clk;
   logic       reset;
   logic       domain0;
   logic       domain1;
   logic [2:0] reqs;
   logic [2:0] grants;
   logic       out_val;
   logic       out_rdy;
   logic [1:0] xbar_sel;

   // Expected output word: {grants, out_val, xbar_sel}.
   logic [5:0] exp_q[$];

   int n_vec  = 0;
   int n_miss = 0;

   // Model state: round-robin pointer per domain, as an input index.
   int ptr[2];

   plab4_net_router_output_ctrl_tp dut (
      .clk      (clk),
      .reset    (reset),
      .domain0  (domain0),
      .domain1  (domain1),
      .reqs     (reqs),
      .grants   (grants),
      .out_val  (out_val),
      .out_rdy  (out_rdy),
      .xbar_sel (xbar_sel)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- model ----------------
   int m_win;
   int m_dom;

   task automatic model_eval(output logic [5:0] e);
      logic [2:0] g;
      logic       v;
      logic [1:0] s;
      int         idx;
      m_win = -1;
      m_dom = domain1 ? 1 : 0;
      if (!reset && (domain0 != domain1)) begin
         for (int k = 0; k < 3; k++) begin
            idx = (ptr[m_dom] + k) % 3;
            if (m_win < 0 && reqs[idx]) m_win = idx;
         end
      end
      v = (m_win >= 0);
      s = v ? 2'(m_win) : 2'd0;
      g = (v && out_rdy) ? 3'(1 << m_win) : 3'b000;
      e = {g, v, s};
   endtask

   task automatic model_step();
      if (reset) begin
         ptr[0] = 0;
         ptr[1] = 0;
      end else if (m_win >= 0 && out_rdy) begin
         ptr[m_dom] = (m_win + 1) % 3;
      end
   endtask

   // ---------------- scoreboard ----------------
   task automatic check_field(input string name, input int act, input int req);
      n_vec++;
      if (act != req) begin
         n_miss++;
         $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, req);
      end
   endtask

   task automatic compare_outputs();
      logic [5:0] e;
      if (exp_q.size() == 0) begin
         n_vec++;
         n_miss++;
         $display("FAIL exp_q_empty t=%0t actual=0 required=1", $time);
         return;
      end
      e = exp_q.pop_front();
      check_field("grants",   int'(grants),   int'(e[5:3]));
      check_field("out_val",  int'(out_val),  int'(e[2]));
      check_field("xbar_sel", int'(xbar_sel), int'(e[1:0]));
   endtask

   // ---------------- driver ----------------
   // Drive one cycle at the falling edge, check 1ns later, update model at the
   // rising edge. When has_lit is set the hand-computed word pins both the
   // model and the DUT.
   task automatic step(input logic rst, input logic d0, input logic d1,
                       input logic [2:0] rq, input logic rdy,
                       input logic has_lit, input logic [5:0] lit);
      logic [5:0] e;
      @(negedge clk);
      reset   = rst;
      domain0 = d0;
      domain1 = d1;
      reqs    = rq;
      out_rdy = rdy;
      #1;
      model_eval(e);
      exp_q.push_back(e);
      if (has_lit) begin
         check_field("model_lit", int'(e), int'(lit));
         check_field("dut_lit", int'({grants, out_val, xbar_sel}), int'(lit));
      end
      compare_outputs();
      @(posedge clk);
      model_step();
   endtask

   task automatic d(input logic rst, input logic d0, input logic d1,
                    input logic [2:0] rq, input logic rdy, input logic [5:0] lit);
      step(rst, d0, d1, rq, rdy, 1'b1, lit);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset = 1'b1; domain0 = 1'b0; domain1 = 1'b0; reqs = '0; out_rdy = 1'b0;
      ptr[0] = 0; ptr[1] = 0;

      // Reset state: outputs forced low.
      d(1, 1, 0, 3'b111, 1, 6'b000_0_00);
      // Basic rotation in domain 0.
      d(0, 1, 0, 3'b111, 1, 6'b001_1_00);
      d(0, 1, 0, 3'b111, 1, 6'b010_1_01);
      d(0, 1, 0, 3'b111, 1, 6'b100_1_10);
      d(0, 1, 0, 3'b111, 1, 6'b001_1_00);

      // Domain isolation.
      d(1, 1, 0, 3'b111, 1, 6'b000_0_00);
      d(0, 1, 0, 3'b111, 1, 6'b001_1_00);
      d(0, 1, 0, 3'b111, 1, 6'b010_1_01);
      d(0, 0, 1, 3'b111, 1, 6'b001_1_00);
      d(0, 1, 0, 3'b111, 1, 6'b100_1_10);

      // Stall holds the pointer; xbar_sel still valid.
      d(0, 1, 0, 3'b110, 0, 6'b000_1_01);
      d(0, 1, 0, 3'b110, 0, 6'b000_1_01);
      d(0, 1, 0, 3'b110, 0, 6'b000_1_01);
      d(0, 1, 0, 3'b110, 1, 6'b010_1_01);
      d(0, 1, 0, 3'b110, 1, 6'b100_1_10);

      // Invalid domain combinations change nothing.
      d(0, 1, 1, 3'b111, 1, 6'b000_0_00);
      d(0, 0, 0, 3'b111, 1, 6'b000_0_00);
      d(0, 1, 0, 3'b111, 1, 6'b001_1_00);

      // Reset mid-run.
      d(1, 1, 0, 3'b111, 1, 6'b000_0_00);
      d(0, 1, 0, 3'b111, 1, 6'b001_1_00);
      d(0, 1, 0, 3'b111, 1, 6'b010_1_01);
      d(1, 1, 0, 3'b111, 1, 6'b000_0_00);
      d(0, 1, 0, 3'b111, 1, 6'b001_1_00);

      // Sparse requests with wrap search in domain 1.
      d(0, 0, 1, 3'b001, 1, 6'b001_1_00);
      d(0, 0, 1, 3'b001, 1, 6'b001_1_00);
      d(0, 0, 1, 3'b011, 1, 6'b010_1_01);
      d(0, 0, 1, 3'b000, 1, 6'b000_0_00);
      d(0, 0, 1, 3'b101, 1, 6'b100_1_10);

      // Randomized traffic checked against the model only.
      for (int i = 0; i < 600; i++) begin
         logic rst, d0, d1, rdy;
         logic [2:0] rq;
         int dsel;
         rst  = ($urandom_range(0, 39) == 0);
         dsel = $urandom_range(0, 9);
         d0   = (dsel < 4) || (dsel == 8);
         d1   = (dsel >= 4 && dsel < 8) || (dsel == 8);
         rq   = 3'($urandom_range(0, 7));
         rdy  = ($urandom_range(0, 3) != 0);
         step(rst, d0, d1, rq, rdy, 1'b0, 6'b0);
      end

      if (exp_q.size() != 0) begin
         n_vec++;
         n_miss++;
         $display("FAIL exp_q_leftover actual=%0d required=0", exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
